// File: rtl/bsg_manycore_edge_mem_responder.sv
// Edge-of-array memory responder: terminates a mesh link and services
// load / store / amoswap / amoadd requests from a small word-addressed flop
// memory, returning in-order responses to the requesting tile.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting requests while the response FIFO has room
// AMO   | AMO operands captured; read-modify-write completes next edge
module bsg_manycore_edge_mem_responder #(
   parameter int data_width_p   = 32,
   parameter int addr_width_p   = 16,
   parameter int x_cord_width_p = 7,
   parameter int y_cord_width_p = 7,
   parameter int reg_id_width_p = 5,
   parameter int mem_els_p      = 256,
   parameter int rsp_fifo_els_p = 2
) (
   input  logic                      clk_i,
   input  logic                      reset_i,

   input  logic                      req_v_i,
   output logic                      req_ready_o,
   input  logic [1:0]                req_op_i,
   input  logic [addr_width_p-1:0]   req_addr_i,
   input  logic [data_width_p-1:0]   req_data_i,
   input  logic [data_width_p/8-1:0] req_mask_i,
   input  logic [reg_id_width_p-1:0] req_reg_id_i,
   input  logic [x_cord_width_p-1:0] req_src_x_i,
   input  logic [y_cord_width_p-1:0] req_src_y_i,

   output logic                      rsp_v_o,
   input  logic                      rsp_yumi_i,
   output logic [1:0]                rsp_type_o,
   output logic [data_width_p-1:0]   rsp_data_o,
   output logic [reg_id_width_p-1:0] rsp_reg_id_o,
   output logic [x_cord_width_p-1:0] rsp_dst_x_o,
   output logic [y_cord_width_p-1:0] rsp_dst_y_o,

   output logic                      oob_err_o
);

   localparam int mask_w_lp = data_width_p / 8;
   localparam int idx_w_lp  = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
   localparam int ptr_w_lp  = (rsp_fifo_els_p > 1) ? $clog2(rsp_fifo_els_p) : 1;
   localparam int cnt_w_lp  = $clog2(rsp_fifo_els_p + 1);

   localparam logic [addr_width_p:0] mem_els_lp  = (addr_width_p+1)'(mem_els_p);
   localparam logic [cnt_w_lp-1:0]   fifo_els_lp = cnt_w_lp'(rsp_fifo_els_p);
   localparam logic [ptr_w_lp-1:0]   ptr_last_lp = ptr_w_lp'(rsp_fifo_els_p - 1);

   localparam logic [1:0] op_load_lp  = 2'd0;
   localparam logic [1:0] op_store_lp = 2'd1;
   localparam logic [1:0] op_swap_lp  = 2'd2;
   localparam logic [1:0] op_add_lp   = 2'd3;

   localparam logic [1:0] rsp_load_lp  = 2'd0;
   localparam logic [1:0] rsp_store_lp = 2'd1;
   localparam logic [1:0] rsp_amo_lp   = 2'd2;

   // elaboration-time parameter sanity
   if ((data_width_p % 8) != 0) begin : g_bad_data_width
      $error("data_width_p must be a multiple of 8");
   end
   if ((mem_els_p < 1) || ((mem_els_p & (mem_els_p - 1)) != 0)) begin : g_bad_mem_els
      $error("mem_els_p must be a power of two");
   end
   if (64'(mem_els_p) > (64'(1) << addr_width_p)) begin : g_bad_mem_range
      $error("mem_els_p must not exceed 2**addr_width_p");
   end
   if (rsp_fifo_els_p < 1) begin : g_bad_fifo_els
      $error("rsp_fifo_els_p must be at least 1");
   end

   typedef enum logic {S_IDLE, S_AMO} state_e;

   typedef struct packed {
      logic [1:0]                typ;
      logic [data_width_p-1:0]   data;
      logic [reg_id_width_p-1:0] reg_id;
      logic [x_cord_width_p-1:0] x;
      logic [y_cord_width_p-1:0] y;
   } rsp_s;

   state_e                    state_r;
   logic                      oob_err_r;
   logic [1:0]                amo_op_r;
   logic [idx_w_lp-1:0]       amo_idx_r;
   logic                      amo_in_range_r;
   logic [data_width_p-1:0]   amo_data_r;
   logic [reg_id_width_p-1:0] amo_reg_id_r;
   logic [x_cord_width_p-1:0] amo_x_r;
   logic [y_cord_width_p-1:0] amo_y_r;

   logic [data_width_p-1:0]   mem [mem_els_p];

   rsp_s                      fifo_mem [rsp_fifo_els_p];
   logic [ptr_w_lp-1:0]       rd_ptr_r, wr_ptr_r;
   logic [cnt_w_lp-1:0]       count_r;

   logic                      accept;
   logic                      req_in_range;
   logic [idx_w_lp-1:0]       req_idx;
   logic [data_width_p-1:0]   rd_data;
   logic [data_width_p-1:0]   amo_old;
   logic [data_width_p-1:0]   amo_new;
   logic                      enq_v;
   rsp_s                      enq_entry;
   logic                      deq;
   rsp_s                      head;

   assign req_ready_o  = (state_r == S_IDLE) && (count_r < fifo_els_lp);
   // an edge with reset held must never touch memory, even if req_v_i is high
   assign accept       = req_v_i && req_ready_o && !reset_i;
   assign req_in_range = ({1'b0, req_addr_i} < mem_els_lp);
   assign req_idx      = req_addr_i[idx_w_lp-1:0];
   assign rd_data      = req_in_range ? mem[req_idx] : '0;

   assign amo_old = amo_in_range_r ? mem[amo_idx_r] : '0;
   assign amo_new = (amo_op_r == op_add_lp) ? (amo_old + amo_data_r) : amo_data_r;

   // build the entry pushed this cycle: AMO completion, or load/store at accept
   always_comb begin
      enq_v     = 1'b0;
      enq_entry = '0;
      if (state_r == S_AMO) begin
         enq_v            = 1'b1;
         enq_entry.typ    = rsp_amo_lp;
         enq_entry.data   = amo_old;
         enq_entry.reg_id = amo_reg_id_r;
         enq_entry.x      = amo_x_r;
         enq_entry.y      = amo_y_r;
      end else if (accept && ((req_op_i == op_load_lp) || (req_op_i == op_store_lp))) begin
         enq_v            = 1'b1;
         enq_entry.typ    = (req_op_i == op_load_lp) ? rsp_load_lp : rsp_store_lp;
         enq_entry.data   = (req_op_i == op_load_lp) ? rd_data : '0;
         enq_entry.reg_id = req_reg_id_i;
         enq_entry.x      = req_src_x_i;
         enq_entry.y      = req_src_y_i;
      end
   end

   // control FSM: AMO operand capture and sticky out-of-range flag
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r        <= S_IDLE;
         oob_err_r      <= 1'b0;
         amo_op_r       <= '0;
         amo_idx_r      <= '0;
         amo_in_range_r <= 1'b0;
         amo_data_r     <= '0;
         amo_reg_id_r   <= '0;
         amo_x_r        <= '0;
         amo_y_r        <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept) begin
                  if (!req_in_range) oob_err_r <= 1'b1;
                  if ((req_op_i == op_swap_lp) || (req_op_i == op_add_lp)) begin
                     amo_op_r       <= req_op_i;
                     amo_idx_r      <= req_idx;
                     amo_in_range_r <= req_in_range;
                     amo_data_r     <= req_data_i;
                     amo_reg_id_r   <= req_reg_id_i;
                     amo_x_r        <= req_src_x_i;
                     amo_y_r        <= req_src_y_i;
                     state_r        <= S_AMO;
                  end
               end
            end
            S_AMO:   state_r <= S_IDLE;
            default: state_r <= S_IDLE;
         endcase
      end
   end

   // word memory: masked store at accept, or AMO write-back (gated by reset-cleared state)
   always_ff @(posedge clk_i) begin
      if (state_r == S_AMO) begin
         if (amo_in_range_r) mem[amo_idx_r] <= amo_new;
      end else if (accept && (req_op_i == op_store_lp) && req_in_range) begin
         for (int b = 0; b < mask_w_lp; b++) begin
            if (req_mask_i[b]) mem[req_idx][b*8 +: 8] <= req_data_i[b*8 +: 8];
         end
      end
   end

   assign deq = rsp_yumi_i && (count_r != '0);

   function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_last_lp) ? '0 : p + 1'b1;
   endfunction

   // response FIFO pointers and occupancy
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (enq_v) wr_ptr_r <= ptr_next(wr_ptr_r);
         if (deq)   rd_ptr_r <= ptr_next(rd_ptr_r);
         case ({enq_v, deq})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // response FIFO storage
   always_ff @(posedge clk_i) begin
      if (enq_v) fifo_mem[wr_ptr_r] <= enq_entry;
   end

   assign head         = fifo_mem[rd_ptr_r];
   assign rsp_v_o      = (count_r != '0);
   assign rsp_type_o   = head.typ;
   assign rsp_data_o   = head.data;
   assign rsp_reg_id_o = head.reg_id;
   assign rsp_dst_x_o  = head.x;
   assign rsp_dst_y_o  = head.y;
   assign oob_err_o    = oob_err_r;

   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(rsp_yumi_i && !rsp_v_o))
      else $error("rsp_yumi_i asserted while rsp_v_o is low");

endmodule

// File: tb/tb_bsg_manycore_edge_mem_responder.sv
// Scoreboard bench for the edge memory responder: a driver issues requests and
// pushes reference-model responses; a monitor consumes and compares in order.
module tb_bsg_manycore_edge_mem_responder;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_v_i;
   logic        req_ready_o;
   logic [1:0]  req_op_i;
   logic [15:0] req_addr_i;
   logic [31:0] req_data_i;
   logic [3:0]  req_mask_i;
   logic [4:0]  req_reg_id_i;
   logic [6:0]  req_src_x_i;
   logic [6:0]  req_src_y_i;
   logic        rsp_v_o;
   logic        rsp_yumi_i;
   logic [1:0]  rsp_type_o;
   logic [31:0] rsp_data_o;
   logic [4:0]  rsp_reg_id_o;
   logic [6:0]  rsp_dst_x_o;
   logic [6:0]  rsp_dst_y_o;
   logic        oob_err_o;

   always #5 clk_i = ~clk_i;

   bsg_manycore_edge_mem_responder dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
      .req_reg_id_i(req_reg_id_i), .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i),
      .rsp_v_o(rsp_v_o), .rsp_yumi_i(rsp_yumi_i), .rsp_type_o(rsp_type_o),
      .rsp_data_o(rsp_data_o), .rsp_reg_id_o(rsp_reg_id_o),
      .rsp_dst_x_o(rsp_dst_x_o), .rsp_dst_y_o(rsp_dst_y_o), .oob_err_o(oob_err_o)
   );

   typedef struct packed {
      logic [1:0]  typ;
      logic [31:0] data;
      logic [4:0]  reg_id;
      logic [6:0]  x;
      logic [6:0]  y;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [31:0] model_mem [256];
   bit          model_oob = 0;
   int          errors = 0;
   int          checks = 0;
   bit          consume_en = 1'b1;
   bit          pulse_req = 1'b0;
   bit          third_done = 1'b0;

   // reference model: apply one accepted request, return its response
   function automatic rsp_t model_apply(input logic [1:0] op, input logic [15:0] addr,
                                        input logic [31:0] data, input logic [3:0] mask,
                                        input logic [4:0] tag, input logic [6:0] x,
                                        input logic [6:0] y);
      rsp_t        r;
      bit          in_range;
      logic [31:0] old;
      in_range = (addr < 16'd256);
      r.reg_id = tag;
      r.x      = x;
      r.y      = y;
      r.data   = 32'd0;
      old      = in_range ? model_mem[addr[7:0]] : 32'd0;
      case (op)
         2'd0: begin r.typ = 2'd0; r.data = old; end
         2'd1: begin
            r.typ = 2'd1;
            if (in_range)
               for (int b = 0; b < 4; b++)
                  if (mask[b]) model_mem[addr[7:0]][b*8 +: 8] = data[b*8 +: 8];
         end
         2'd2: begin r.typ = 2'd2; r.data = old; if (in_range) model_mem[addr[7:0]] = data; end
         default: begin r.typ = 2'd2; r.data = old; if (in_range) model_mem[addr[7:0]] = old + data; end
      endcase
      if (!in_range) model_oob = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // caller sits at posedge+1; returns at posedge+1 after the accept edge
   task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [4:0] tag, input logic [6:0] x,
                        input logic [6:0] y);
      int waited = 0;
      req_op_i = op; req_addr_i = addr; req_data_i = data; req_mask_i = mask;
      req_reg_id_i = tag; req_src_x_i = x; req_src_y_i = y;
      req_v_i = 1'b1;
      while (!req_ready_o) begin
         @(posedge clk_i); #1;
         waited++;
         if (waited > 1000) begin
            checks++; errors++;
            $display("FAIL issue_timeout: ready never rose for op %0d addr %0h", op, addr);
            req_v_i = 1'b0;
            return;
         end
      end
      @(posedge clk_i);
      exp_q.push_back(model_apply(op, addr, data, mask, tag, x, y));
      #1 req_v_i = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || rsp_v_o) && n < 3000) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("drain_timeout", 64'(n >= 3000), 64'd0);
   endtask

   // monitor: decides yumi at negedge and compares each taken response in order
   always @(negedge clk_i) begin
      bit   take;
      rsp_t got;
      take = 1'b0;
      if (!reset_i && rsp_v_o) begin
         if (consume_en) take = ($urandom_range(0, 99) < 70);
         else if (pulse_req) begin take = 1'b1; pulse_req = 1'b0; end
         if (take) begin
            got = {rsp_type_o, rsp_data_o, rsp_reg_id_o, rsp_dst_x_o, rsp_dst_y_o};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got %0h with nothing expected", got);
            end else begin
               if (got !== exp_q[0]) begin
                  errors++;
                  $display("FAIL rsp: got %0h expected %0h", got, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
      end
      rsp_yumi_i = take;
   end

   initial begin
      logic [31:0] saved;
      int          n;
      reset_i = 1'b1; rsp_yumi_i = 1'b0;
      req_v_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
      req_reg_id_i = '0; req_src_x_i = '0; req_src_y_i = '0;
      #22;
      check("rst_rsp_v", 64'(rsp_v_o), 64'd0);
      check("rst_ready", 64'(req_ready_o), 64'd1);
      check("rst_oob", 64'(oob_err_o), 64'd0);
      @(negedge clk_i) reset_i = 1'b0;
      @(posedge clk_i); #1;

      // full-word store, latency-1 ack, readback
      issue(2'd1, 16'd5, 32'hDEADBEEF, 4'hF, 5'd3, 7'd2, 7'd1);
      @(negedge clk_i);
      check("store_latency", 64'(rsp_v_o), 64'd1);
      @(posedge clk_i); #1;
      issue(2'd0, 16'd5, 32'h0, 4'h0, 5'd4, 7'd3, 7'd2);

      // partial mask store then back-to-back load of the same word
      issue(2'd1, 16'd5, 32'h11223344, 4'h5, 5'd5, 7'd1, 7'd1);
      issue(2'd0, 16'd5, 32'h0, 4'h0, 5'd6, 7'd1, 7'd1);
      issue(2'd1, 16'd5, 32'hFFFFFFFF, 4'h0, 5'd7, 7'd1, 7'd1);
      issue(2'd0, 16'd5, 32'h0, 4'h0, 5'd8, 7'd1, 7'd1);

      // amoadd with wrap, ready low for exactly one cycle
      issue(2'd1, 16'd9, 32'hFFFFFFFE, 4'hF, 5'd9, 7'd4, 7'd4);
      wait_drain();
      issue(2'd3, 16'd9, 32'd7, 4'h0, 5'd10, 7'd4, 7'd5);
      check("amo_ready_low", 64'(req_ready_o), 64'd0);
      @(posedge clk_i); #1;
      check("amo_ready_back", 64'(req_ready_o), 64'd1);
      issue(2'd0, 16'd9, 32'h0, 4'h0, 5'd11, 7'd4, 7'd6);
      wait_drain();

      // back-pressure: FIFO of two fills, one yumi admits the third load
      consume_en = 1'b0;
      issue(2'd0, 16'd5, 32'h0, 4'h0, 5'd12, 7'd7, 7'd0);
      issue(2'd0, 16'd9, 32'h0, 4'h0, 5'd13, 7'd7, 7'd1);
      check("full_ready_low", 64'(req_ready_o), 64'd0);
      fork
         begin issue(2'd0, 16'd5, 32'h0, 4'h0, 5'd14, 7'd7, 7'd2); third_done = 1'b1; end
      join_none
      @(posedge clk_i); #1;
      check("full_still_low", 64'(req_ready_o), 64'd0);
      pulse_req = 1'b1;
      @(posedge clk_i); #1;
      check("ready_after_yumi", 64'(req_ready_o), 64'd1);
      n = 0;
      while (!third_done && n < 100) begin @(posedge clk_i); #1; n++; end
      check("third_accepted", 64'(third_done), 64'd1);
      check("full_again_low", 64'(req_ready_o), 64'd0);
      consume_en = 1'b1;
      wait_drain();

      // out-of-range load, sticky flag, in-range unaffected
      issue(2'd0, 16'd256, 32'h0, 4'h0, 5'd15, 7'd9, 7'd9);
      issue(2'd1, 16'd300, 32'h12345678, 4'hF, 5'd16, 7'd9, 7'd9);
      issue(2'd0, 16'd5, 32'h0, 4'h0, 5'd17, 7'd9, 7'd9);
      @(posedge clk_i); #1;
      check("oob_set", 64'(oob_err_o), 64'd1);
      wait_drain();
      check("oob_sticky", 64'(oob_err_o), 64'd1);

      // reset while the AMO is pending: FIFO cleared at once, write suppressed
      consume_en = 1'b0;
      issue(2'd1, 16'd20, 32'hCAFEF00D, 4'hF, 5'd18, 7'd1, 7'd3);
      saved = model_mem[20];
      issue(2'd2, 16'd20, 32'h12345678, 4'h0, 5'd19, 7'd1, 7'd3);
      check("pre_rst_rsp_v", 64'(rsp_v_o), 64'd1);
      reset_i = 1'b1;
      #1;
      check("rst_async_rsp_v", 64'(rsp_v_o), 64'd0);
      exp_q.delete();
      model_mem[20] = saved;
      model_oob = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i) reset_i = 1'b0;
      consume_en = 1'b1;
      @(posedge clk_i); #1;
      check("post_rst_ready", 64'(req_ready_o), 64'd1);
      check("post_rst_oob", 64'(oob_err_o), 64'd0);
      issue(2'd0, 16'd20, 32'h0, 4'h0, 5'd20, 7'd1, 7'd3);
      wait_drain();

      // randomized traffic over a fully initialised memory
      for (int a = 0; a < 256; a++)
         issue(2'd1, 16'(a), $urandom, 4'hF, 5'(a), 7'(a), 7'(a >> 1));
      for (int i = 0; i < 400; i++) begin
         logic [15:0] addr;
         addr = ($urandom_range(0, 99) < 95) ? 16'($urandom_range(0, 255))
                                              : 16'($urandom_range(256, 300));
         issue(2'($urandom_range(0, 3)), addr, $urandom, 4'($urandom_range(0, 15)),
               5'($urandom), 7'($urandom), 7'($urandom));
      end
      wait_drain();
      check("final_oob", 64'(oob_err_o), 64'(model_oob));
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
